// File: rtl/bus_initiator_0_pkg.sv
// Shared cache/bus definitions: address width, request encodings and the
// initiator FSM state encoding.
package bus_initiator_0_pkg;

  localparam int ADDRESSSIZE = 32;
  localparam int TIMER_W     = 8;

  typedef enum logic [1:0] {
    RD_MISS   = 2'b00,
    WR_MISS   = 2'b01,
    UPGRADE   = 2'b10,
    WRITEBACK = 2'b11
  } req_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_WAIT,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bus_initiator_0_if.sv
// Snoop-bus side of the initiator: arbitration, commands, address/data and
// the wired-OR responses from the other caches and memory.
interface bus_initiator_0_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Bus_req;
  logic              Bus_grant;
  logic              BusRd;
  logic              BusRdX;
  logic              Invalidate;
  logic              Mem_wr;
  logic [ADDR_W-1:0] Address_Com;
  logic [DATA_W-1:0] Data_Com_out;
  logic              Data_Com_oe;
  logic [DATA_W-1:0] Data_Com_in;
  logic              Shared_in;
  logic              Flush_in;
  logic              Mem_ack;

  modport master (
    output Bus_req, BusRd, BusRdX, Invalidate, Mem_wr,
           Address_Com, Data_Com_out, Data_Com_oe,
    input  Bus_grant, Data_Com_in, Shared_in, Flush_in, Mem_ack
  );

  modport slave (
    input  Bus_req, BusRd, BusRdX, Invalidate, Mem_wr,
           Address_Com, Data_Com_out, Data_Com_oe,
    output Bus_grant, Data_Com_in, Shared_in, Flush_in, Mem_ack
  );
endinterface

// File: rtl/bus_initiator_0_timer.sv
// Watchdog for the data/ack phase: counts while enabled, flags expiry on the
// TIMEOUT-th waiting cycle.
module bus_txn_timer_0
  import bus_initiator_0_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TIMER_W-1:0] LP_LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  // Count value c is the (c+1)-th waiting cycle, so expiry is at TIMEOUT-1.
  assign o_expired = i_en && (r_count == LP_LAST);

endmodule

// File: rtl/bus_initiator_0.sv
// Snoop-bus transaction initiator for one L1 cache: arbitrates, issues
// BusRd/BusRdX/Invalidate/Mem_wr and returns fill data and the Shared result.
module bus_initiator_0
  import bus_initiator_0_pkg::*;
#(
  parameter int ADDR_W  = ADDRESSSIZE,
  parameter int DATA_W  = ADDRESSSIZE,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req_valid,
  input  logic [1:0]        Req_type,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [DATA_W-1:0] Req_wb_data,
  output logic              Req_ready,
  output logic              Done,
  output logic              Error,
  output logic [DATA_W-1:0] Fill_data,
  output logic              Shared_result,
  bus_initiator_0_if.master bus
);

  state_t            r_state, w_next;
  req_type_t         r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [DATA_W-1:0] r_fill;
  logic              r_shared;
  logic              r_err;

  logic              w_accept, w_fill, w_timeout, w_expired, w_waiting;
  logic              w_bus_req, w_rd, w_rdx, w_inv, w_mem_wr, w_oe;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_dout;

  assign w_waiting = (r_state == ST_WAIT) || (r_state == ST_WB);

  bus_txn_timer_0 #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_waiting),
    .i_en      (w_waiting),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_fill    = 1'b0;
    w_timeout = 1'b0;
    w_bus_req = 1'b0;
    w_rd      = 1'b0;
    w_rdx     = 1'b0;
    w_inv     = 1'b0;
    w_mem_wr  = 1'b0;
    w_oe      = 1'b0;
    w_addr    = '0;
    w_dout    = '0;
    case (r_state)
      ST_IDLE: begin
        if (Req_valid) begin
          w_accept = 1'b1;
          w_next   = ST_ARB;
        end
      end
      ST_ARB: begin
        w_bus_req = 1'b1;
        if (bus.Bus_grant) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        w_bus_req = 1'b1;
        w_addr    = r_addr;
        case (r_type)
          RD_MISS:   begin w_rd  = 1'b1; w_next = ST_WAIT; end
          WR_MISS:   begin w_rdx = 1'b1; w_next = ST_WAIT; end
          UPGRADE:   begin w_inv = 1'b1; w_next = ST_DONE; end
          WRITEBACK: begin
            w_mem_wr = 1'b1;
            w_oe     = 1'b1;
            w_dout   = r_wb_data;
            w_next   = ST_WB;
          end
          default:   w_next = ST_DONE;
        endcase
      end
      ST_WAIT: begin
        w_bus_req = 1'b1;
        w_addr    = r_addr;
        if (bus.Flush_in || bus.Mem_ack) begin
          w_fill = 1'b1;
          w_next = ST_DONE;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_WB: begin
        w_bus_req = 1'b1;
        w_addr    = r_addr;
        w_mem_wr  = 1'b1;
        w_oe      = 1'b1;
        w_dout    = r_wb_data;
        if (bus.Mem_ack) begin
          w_next = ST_DONE;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type    <= RD_MISS;
      r_addr    <= '0;
      r_wb_data <= '0;
      r_fill    <= '0;
      r_shared  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type    <= req_type_t'(Req_type);
        r_addr    <= Req_addr;
        r_wb_data <= Req_wb_data;
        r_shared  <= 1'b0;
        r_err     <= 1'b0;
      end
      if (r_state == ST_ADDR) r_shared <= bus.Shared_in;
      if (w_fill) begin
        r_fill <= bus.Data_Com_in;
        // An owner flushing on a read means another cache keeps a copy.
        if (bus.Flush_in && (r_type == RD_MISS)) r_shared <= 1'b1;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign Req_ready       = (r_state == ST_IDLE);
  assign Done            = (r_state == ST_DONE);
  assign Error           = Done && r_err;
  assign Shared_result   = Done && r_shared;
  assign Fill_data       = r_fill;

  assign bus.Bus_req      = w_bus_req;
  assign bus.BusRd        = w_rd;
  assign bus.BusRdX       = w_rdx;
  assign bus.Invalidate   = w_inv;
  assign bus.Mem_wr       = w_mem_wr;
  assign bus.Data_Com_oe  = w_oe;
  assign bus.Address_Com  = w_addr;
  assign bus.Data_Com_out = w_dout;

endmodule

// File: tb/tb_bus_initiator_0.sv
// Directed bench for bus_initiator_0: table of whole transactions plus
// hand-written timeout and mid-transaction reset sequences.
module tb_bus_initiator_0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        Req_valid, Req_ready, Done, Error, Shared_result;
  logic [1:0]  Req_type;
  logic [31:0] Req_addr, Req_wb_data, Fill_data;

  logic        t_Req_valid, t_Req_ready, t_Done, t_Error, t_Shared_result;
  logic [1:0]  t_Req_type;
  logic [31:0] t_Req_addr, t_Req_wb_data, t_Fill_data;

  bus_initiator_0_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  bus_initiator_0_if #(.ADDR_W(32), .DATA_W(32)) bus_t ();

  bus_initiator_0 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .Req_valid(Req_valid), .Req_type(Req_type),
    .Req_addr(Req_addr), .Req_wb_data(Req_wb_data), .Req_ready(Req_ready),
    .Done(Done), .Error(Error), .Fill_data(Fill_data),
    .Shared_result(Shared_result), .bus(bus)
  );

  bus_initiator_0 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(rst), .Req_valid(t_Req_valid), .Req_type(t_Req_type),
    .Req_addr(t_Req_addr), .Req_wb_data(t_Req_wb_data), .Req_ready(t_Req_ready),
    .Done(t_Done), .Error(t_Error), .Fill_data(t_Fill_data),
    .Shared_result(t_Shared_result), .bus(bus_t)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wbd;
    int          gdly;    // cycles of grant delay after entering ARB
    int          ackdly;  // ack offset from first WAIT/WB cycle
    logic        shr;     // Shared_in during the ADDR cycle
    logic        flush;   // Flush_in together with Mem_ack
    logic [31:0] rdata;
    logic [31:0] exp_fill;
    logic        exp_shr;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  // Cycle 0 is the acceptance cycle. Spurious Mem_ack/Flush_in in ARB and a
  // second Req_valid with other type/address in ARB must both be ignored.
  task automatic run_vec(input vec_t v, input int idx);
    int n_rd, n_rdx, n_inv, n_wr, n_oe, done_c, ack_c;
    bit seq_ok;
    n_rd = 0; n_rdx = 0; n_inv = 0; n_wr = 0; n_oe = 0;
    done_c = -1; seq_ok = 1'b1;
    ack_c = 3 + v.gdly + v.ackdly;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      Req_valid       = (c <= 1);
      Req_type        = (c == 0) ? v.typ  : ~v.typ;
      Req_addr        = (c == 0) ? v.addr : ~v.addr;
      Req_wb_data     = (c == 0) ? v.wbd  : ~v.wbd;
      bus.Bus_grant   = (c >= 1 + v.gdly);
      bus.Shared_in   = (c == 2 + v.gdly) ? v.shr : 1'b0;
      bus.Mem_ack     = (c == ack_c) || (c == 1);
      bus.Flush_in    = ((c == ack_c) && v.flush) || (c == 1);
      bus.Data_Com_in = (c == ack_c) ? v.rdata : (32'hBAD0_0000 + 32'(c));
      @(negedge clk);
      if (bus.BusRd)       n_rd++;
      if (bus.BusRdX)      n_rdx++;
      if (bus.Invalidate)  n_inv++;
      if (bus.Mem_wr)      n_wr++;
      if (bus.Data_Com_oe) n_oe++;
      if (Req_ready !== (c == 0)) seq_ok = 1'b0;
      if (bus.Bus_req !== (c >= 1 && c < v.exp_done)) seq_ok = 1'b0;
      if (bus.Data_Com_oe && (bus.Data_Com_out !== v.wbd)) seq_ok = 1'b0;
      if (c == 2 + v.gdly) chk($sformatf("v%0d addr", idx), bus.Address_Com, v.addr);
      if (Done === 1'b1) begin
        done_c = c;
        chk($sformatf("v%0d fill", idx),   Fill_data,     v.exp_fill);
        chk($sformatf("v%0d shared", idx), 32'(Shared_result), 32'(v.exp_shr));
        chk($sformatf("v%0d error", idx),  32'(Error),    32'd0);
      end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d done_cycle", idx), done_c, v.exp_done);
    chk($sformatf("v%0d busrd", idx),  n_rd,  (v.typ == 2'b00) ? 1 : 0);
    chk($sformatf("v%0d busrdx", idx), n_rdx, (v.typ == 2'b01) ? 1 : 0);
    chk($sformatf("v%0d inval", idx),  n_inv, (v.typ == 2'b10) ? 1 : 0);
    chk($sformatf("v%0d memwr", idx),  n_wr,  (v.typ == 2'b11) ? v.exp_done - 2 - v.gdly : 0);
    chk($sformatf("v%0d oe", idx),     n_oe,  (v.typ == 2'b11) ? v.exp_done - 2 - v.gdly : 0);
    chk($sformatf("v%0d seq", idx),    32'(seq_ok), 32'd1);
  endtask

  task automatic idle_inputs();
    Req_valid = 1'b0; Req_type = 2'b00; Req_addr = '0; Req_wb_data = '0;
    bus.Bus_grant = 1'b0; bus.Shared_in = 1'b0; bus.Flush_in = 1'b0;
    bus.Mem_ack = 1'b0; bus.Data_Com_in = '0;
    t_Req_valid = 1'b0; t_Req_type = 2'b00; t_Req_addr = '0; t_Req_wb_data = '0;
    bus_t.Bus_grant = 1'b0; bus_t.Shared_in = 1'b0; bus_t.Flush_in = 1'b0;
    bus_t.Mem_ack = 1'b0; bus_t.Data_Com_in = '0;
  endtask

  initial begin
    bit ok;
    vecs[0] = '{typ:2'b00, addr:32'h0000_1A40, wbd:32'h0, gdly:2, ackdly:0, shr:1'b1,
                flush:1'b0, rdata:32'hDEAD_BEEF, exp_fill:32'hDEAD_BEEF, exp_shr:1'b1, exp_done:6};
    vecs[1] = '{typ:2'b01, addr:32'h0000_2000, wbd:32'h0, gdly:0, ackdly:0, shr:1'b0,
                flush:1'b1, rdata:32'h1234_5678, exp_fill:32'h1234_5678, exp_shr:1'b0, exp_done:4};
    vecs[2] = '{typ:2'b10, addr:32'h0000_0080, wbd:32'h0, gdly:0, ackdly:0, shr:1'b1,
                flush:1'b0, rdata:32'h5555_AAAA, exp_fill:32'h1234_5678, exp_shr:1'b1, exp_done:3};
    vecs[3] = '{typ:2'b00, addr:32'h0000_03C0, wbd:32'h0, gdly:1, ackdly:2, shr:1'b0,
                flush:1'b1, rdata:32'h0BAD_F00D, exp_fill:32'h0BAD_F00D, exp_shr:1'b1, exp_done:7};
    vecs[4] = '{typ:2'b11, addr:32'h0000_4440, wbd:32'hCAFE_F00D, gdly:0, ackdly:4, shr:1'b0,
                flush:1'b0, rdata:32'h7777_7777, exp_fill:32'h0BAD_F00D, exp_shr:1'b0, exp_done:8};
    vecs[5] = '{typ:2'b00, addr:32'h0000_5000, wbd:32'h0, gdly:0, ackdly:1, shr:1'b0,
                flush:1'b0, rdata:32'h1357_9BDF, exp_fill:32'h1357_9BDF, exp_shr:1'b0, exp_done:5};

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(Req_ready), 32'd1);
    chk("rst bus_req",   32'(bus.Bus_req), 32'd0);
    chk("rst done",      32'(Done), 32'd0);
    chk("rst fill",      Fill_data, 32'h0);
    chk("rst addr",      bus.Address_Com, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    idle_inputs();

    // Watchdog on the TIMEOUT=4 instance: WAIT entered in cycle 3, Done in 7.
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      t_Req_valid = (c == 0); t_Req_type = 2'b00; t_Req_addr = 32'h0000_9000;
      bus_t.Bus_grant = (c >= 1);
      @(negedge clk);
      if (c < 7 && t_Done !== 1'b0) ok = 1'b0;
      if (c == 7) begin
        chk("to done", 32'(t_Done), 32'd1);
        chk("to error", 32'(t_Error), 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("to no early done", 32'(ok), 32'd1);
    // Back-to-back request accepted as Req_ready rises; ack on the last
    // permitted WAIT cycle beats the timeout.
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      t_Req_valid = (c == 0); t_Req_addr = 32'h0000_A000;
      bus_t.Bus_grant = (c >= 1);
      bus_t.Mem_ack = (c == 6);
      bus_t.Data_Com_in = (c == 6) ? 32'h2468_ACE0 : 32'hFFFF_0000;
      @(negedge clk);
      if (c == 0) chk("to2 ready", 32'(t_Req_ready), 32'd1);
      if (c == 1) chk("to2 accepted", {30'd0, t_Req_ready, bus_t.Bus_req}, 32'd1);
      if (c < 7 && t_Done !== 1'b0) ok = 1'b0;
      if (c == 7) begin
        chk("to2 done", 32'(t_Done), 32'd1);
        chk("to2 error", 32'(t_Error), 32'd0);
        chk("to2 fill", t_Fill_data, 32'h2468_ACE0);
      end
      @(posedge clk); #1;
    end
    chk("to2 no early done", 32'(ok), 32'd1);
    idle_inputs();

    // Reset asserted mid-WAIT on the main instance.
    for (int c = 0; c < 4; c++) begin
      Req_valid = (c == 0); Req_type = 2'b00; Req_addr = 32'h0000_6000;
      bus.Bus_grant = (c >= 1);
      @(negedge clk);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("wait addr held", bus.Address_Com, 32'h0000_6000);
    chk("wait cmds low", {29'd0, bus.BusRd, bus.BusRdX, bus.Invalidate}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst bus_req", 32'(bus.Bus_req), 32'd0);
    chk("arst addr", bus.Address_Com, 32'h0);
    chk("arst fill", Fill_data, 32'h0);
    chk("arst ready", 32'(Req_ready), 32'd1);
    chk("arst done", 32'(Done), 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.Mem_ack = 1'b1;
      @(negedge clk);
      if (Done !== 1'b0 || Req_ready !== 1'b1 || bus.Bus_req !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("post-rst idle", 32'(ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
